// File: rtl/mem_sequencer_pkg.sv
// mem_seq_pkg: op codes, sequencer states, select encodings and beat helpers for mem_sequencer
package mem_seq_pkg;
  typedef enum logic [2:0] {OP_NONE, OP_LDD, OP_STD, OP_PUSH, OP_POP, OP_CALL, OP_RET, OP_RTI} mem_op_t;
  typedef enum logic [3:0] {S_IDLE, S_CALL_LO, S_RET_HI, S_RET_PC, S_RTI_HI, S_RTI_FL, S_INT_FL, S_INT_HI, S_INT_LO} seq_state_t;
  localparam logic [1:0] ADDR_SEL_STD = 2'b00;
  localparam logic [1:0] ADDR_SEL_LDD = 2'b01;
  localparam logic [1:0] ADDR_SEL_SP = 2'b10;
  localparam logic [1:0] WSRC_FLAGS = 2'b00;
  localparam logic [1:0] WSRC_PC_HI = 2'b01;
  localparam logic [1:0] WSRC_PC_LO = 2'b10;
  localparam logic [1:0] WSRC_REG = 2'b11;
  typedef struct packed {
    logic read;
    logic write;
    logic push;
    logic pop;
    logic [1:0] addr_sel;
    logic [1:0] wsrc;
    logic pc_mem;
    logic intr;
    logic flags_restore;
    logic stall;
  } ctrl_t;
  function automatic ctrl_t push_beat(input logic [1:0] src, input logic stall);
    ctrl_t c;
    c = '0;
    c.write = 1'b1;
    c.push = 1'b1;
    c.addr_sel = ADDR_SEL_SP;
    c.wsrc = src;
    c.stall = stall;
    return c;
  endfunction
  function automatic ctrl_t pop_beat(input logic stall);
    ctrl_t c;
    c = '0;
    c.read = 1'b1;
    c.pop = 1'b1;
    c.addr_sel = ADDR_SEL_SP;
    c.stall = stall;
    return c;
  endfunction
endpackage

// File: rtl/mem_sequencer_if.sv
// mem_sequencer_if: upstream op/interrupt inputs and memory-stage controls; stall_cycles only with MEM_SEQ_PERF_EN
interface mem_sequencer_if
`ifdef MEM_SEQ_PERF_EN
  #(parameter int CNT_W = 16)
`endif
  ;
  logic op_valid;
  mem_seq_pkg::mem_op_t op;
  logic int_req;
  logic memory_read;
  logic memory_write;
  logic memory_push;
  logic memory_pop;
  logic [1:0] memory_address_select;
  logic [1:0] memory_write_src_select;
  logic pc_choose_memory;
  logic interrupt;
  logic flags_restore;
  logic stall;
`ifdef MEM_SEQ_PERF_EN
  logic [CNT_W-1:0] stall_cycles;
  modport master(output op_valid, op, int_req,
    input memory_read, memory_write, memory_push, memory_pop, memory_address_select,
    memory_write_src_select, pc_choose_memory, interrupt, flags_restore, stall, stall_cycles);
  modport slave(input op_valid, op, int_req,
    output memory_read, memory_write, memory_push, memory_pop, memory_address_select,
    memory_write_src_select, pc_choose_memory, interrupt, flags_restore, stall, stall_cycles);
`else
  modport master(output op_valid, op, int_req,
    input memory_read, memory_write, memory_push, memory_pop, memory_address_select,
    memory_write_src_select, pc_choose_memory, interrupt, flags_restore, stall);
  modport slave(input op_valid, op, int_req,
    output memory_read, memory_write, memory_push, memory_pop, memory_address_select,
    memory_write_src_select, pc_choose_memory, interrupt, flags_restore, stall);
`endif
endinterface

// File: rtl/mem_sequencer.sv
// mem_sequencer: splits CALL/RET/RTI/interrupt stack traffic into 16-bit beats; MEM_SEQ_PERF_EN adds stall_cycles
module mem_sequencer
  import mem_seq_pkg::*;
`ifdef MEM_SEQ_PERF_EN
  #(parameter int CNT_W = 16)
`endif
(
  input logic clk,
  input logic reset,
  mem_sequencer_if.slave bus
);
  seq_state_t state;
  logic int_pending;
  mem_op_t op;
  logic in_int;
  logic pend;
  ctrl_t c;
  ctrl_t ctl;
  assign op = bus.op_valid ? bus.op : OP_NONE;
  assign in_int = state inside {S_INT_FL, S_INT_HI, S_INT_LO};
  assign pend = int_pending | bus.int_req;
  // Sequence state and interrupt latch; a multi-beat op started in IDLE wins over a pending interrupt
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      int_pending <= 1'b0;
    end else begin
      int_pending <= in_int ? int_pending & (state != S_INT_LO) : pend;
      case (state)
        S_IDLE: state <= op == OP_CALL ? S_CALL_LO : op == OP_RET ? S_RET_HI : op == OP_RTI ? S_RTI_HI : pend ? S_INT_FL : S_IDLE;
        S_RET_HI: state <= S_RET_PC;
        S_RTI_HI: state <= S_RTI_FL;
        S_INT_FL: state <= S_INT_HI;
        S_INT_HI: state <= S_INT_LO;
        default: state <= S_IDLE;
      endcase
    end
  // Beat decode: Mealy on the incoming op in IDLE, state-only elsewhere
  always_comb begin
    c = '0;
    case (state)
      S_IDLE:
        case (op)
          OP_LDD: begin
            c.read = 1'b1;
            c.addr_sel = ADDR_SEL_LDD;
          end
          OP_STD: begin
            c.write = 1'b1;
            c.addr_sel = ADDR_SEL_STD;
            c.wsrc = WSRC_REG;
          end
          OP_PUSH: c = push_beat(WSRC_REG, 1'b0);
          OP_POP: c = pop_beat(1'b0);
          OP_CALL: c = push_beat(WSRC_PC_HI, 1'b1);
          OP_RET, OP_RTI: c = pop_beat(1'b1);
          default: c = '0;
        endcase
      S_CALL_LO: c = push_beat(WSRC_PC_LO, 1'b0);
      S_RET_HI, S_RTI_HI: c = pop_beat(1'b1);
      S_RET_PC: c.pc_mem = 1'b1;
      S_RTI_FL: begin
        c = pop_beat(1'b0);
        c.pc_mem = 1'b1;
        c.flags_restore = 1'b1;
      end
      S_INT_FL: c = push_beat(WSRC_FLAGS, 1'b1);
      S_INT_HI: c = push_beat(WSRC_PC_HI, 1'b1);
      S_INT_LO: begin
        c = push_beat(WSRC_PC_LO, 1'b1);
        c.intr = 1'b1;
      end
      default: c = '0;
    endcase
  end
  // Reset must silence the Mealy path immediately, not just at the next edge
  assign ctl = reset ? c : '0;
  assign bus.memory_read = ctl.read;
  assign bus.memory_write = ctl.write;
  assign bus.memory_push = ctl.push;
  assign bus.memory_pop = ctl.pop;
  assign bus.memory_address_select = ctl.addr_sel;
  assign bus.memory_write_src_select = ctl.wsrc;
  assign bus.pc_choose_memory = ctl.pc_mem;
  assign bus.interrupt = ctl.intr;
  assign bus.flags_restore = ctl.flags_restore;
  assign bus.stall = ctl.stall;
`ifdef MEM_SEQ_PERF_EN
  logic [CNT_W-1:0] cnt;
  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (ctl.stall && !(&cnt)) cnt <= cnt + CNT_W'(1);
  assign bus.stall_cycles = cnt;
`endif
endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: directed checks of beat sequencing, interrupt entry and reset; counter checks with MEM_SEQ_PERF_EN
module tb_mem_sequencer;
  import mem_seq_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
`ifdef MEM_SEQ_PERF_EN
  mem_sequencer_if #(.CNT_W(16)) bus();
  mem_sequencer_if #(.CNT_W(2)) bus2();
  mem_sequencer #(.CNT_W(16)) dut(.clk(clk), .reset(reset), .bus(bus));
  mem_sequencer #(.CNT_W(2)) dut2(.clk(clk), .reset(reset), .bus(bus2));
  assign bus2.op_valid = bus.op_valid;
  assign bus2.op = bus.op;
  assign bus2.int_req = bus.int_req;
`else
  mem_sequencer_if bus();
  mem_sequencer dut(.clk(clk), .reset(reset), .bus(bus));
`endif
  // {read,write,push,pop, addr_sel, wsrc, pc_choose,interrupt,flags_restore,stall}
  function automatic logic [15:0] outs();
    return {4'b0, bus.memory_read, bus.memory_write, bus.memory_push, bus.memory_pop,
            bus.memory_address_select, bus.memory_write_src_select,
            bus.pc_choose_memory, bus.interrupt, bus.flags_restore, bus.stall};
  endfunction
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic v, input mem_op_t o, input logic i);
    @(negedge clk);
    bus.op_valid = v;
    bus.op = o;
    bus.int_req = i;
    #1;
  endtask
  initial begin
    bus.op_valid = 1'b1;
    bus.op = OP_LDD;
    bus.int_req = 1'b0;
    #3 chk("reset_outputs", outs(), 16'b0000_0000_00_00_0000);
`ifdef MEM_SEQ_PERF_EN
    chk("reset_cnt", 16'(bus.stall_cycles), 16'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    cyc(1, OP_RET, 0);  chk("ret_b0", outs(), 16'b0000_1001_10_00_0001);
    cyc(0, OP_NONE, 0); chk("ret_hi", outs(), 16'b0000_1001_10_00_0001);
    bus.op_valid = 1'b1;
    bus.op = OP_CALL;
    #2 reset = 1'b0;
    #1 chk("async_reset", outs(), 16'b0000_0000_00_00_0000);
    @(posedge clk);
    #1 reset = 1'b1;
    cyc(1, OP_CALL, 0); chk("call_b0_after_reset", outs(), 16'b0000_0110_10_01_0001);
    cyc(0, OP_NONE, 0); chk("call_lo", outs(), 16'b0000_0110_10_10_0000);
    cyc(1, OP_STD, 0);  chk("std_after_call", outs(), 16'b0000_0100_00_11_0000);
    cyc(0, OP_NONE, 0); chk("idle", outs(), 16'b0000_0000_00_00_0000);
    cyc(1, OP_LDD, 0);  chk("ldd", outs(), 16'b0000_1000_01_00_0000);
    cyc(1, OP_PUSH, 0); chk("push", outs(), 16'b0000_0110_10_11_0000);
    cyc(1, OP_POP, 0);  chk("pop", outs(), 16'b0000_1001_10_00_0000);
    cyc(1, OP_NONE, 0); chk("op_none", outs(), 16'b0000_0000_00_00_0000);
    cyc(1, OP_RTI, 0);  chk("rti_b0", outs(), 16'b0000_1001_10_00_0001);
    cyc(1, OP_LDD, 0);  chk("rti_hi_ignores_op", outs(), 16'b0000_1001_10_00_0001);
    cyc(1, OP_LDD, 0);  chk("rti_fl", outs(), 16'b0000_1001_10_00_1010);
    cyc(0, OP_NONE, 0); chk("rti_done", outs(), 16'b0000_0000_00_00_0000);
    cyc(1, OP_RET, 0);  chk("ret2_b0", outs(), 16'b0000_1001_10_00_0001);
    cyc(0, OP_NONE, 0); chk("ret2_hi", outs(), 16'b0000_1001_10_00_0001);
    cyc(0, OP_NONE, 0); chk("ret2_pc", outs(), 16'b0000_0000_00_00_1000);
    cyc(0, OP_NONE, 0); chk("ret2_done", outs(), 16'b0000_0000_00_00_0000);
    cyc(1, OP_CALL, 1); chk("int_call_b0", outs(), 16'b0000_0110_10_01_0001);
    cyc(0, OP_NONE, 0); chk("int_call_lo", outs(), 16'b0000_0110_10_10_0000);
    cyc(0, OP_NONE, 0); chk("int_gap_idle", outs(), 16'b0000_0000_00_00_0000);
    cyc(0, OP_NONE, 0); chk("int_fl", outs(), 16'b0000_0110_10_00_0001);
    cyc(0, OP_NONE, 0); chk("int_hi", outs(), 16'b0000_0110_10_01_0001);
    cyc(0, OP_NONE, 0); chk("int_lo", outs(), 16'b0000_0110_10_10_0101);
    cyc(0, OP_NONE, 0); chk("int_done", outs(), 16'b0000_0000_00_00_0000);
    cyc(1, OP_PUSH, 1); chk("push_with_int", outs(), 16'b0000_0110_10_11_0000);
    cyc(1, OP_LDD, 1);  chk("int5_fl", outs(), 16'b0000_0110_10_00_0001);
    cyc(1, OP_LDD, 1);  chk("int5_hi", outs(), 16'b0000_0110_10_01_0001);
    cyc(1, OP_LDD, 1);  chk("int5_lo", outs(), 16'b0000_0110_10_10_0101);
    cyc(0, OP_NONE, 0); chk("merged_idle1", outs(), 16'b0000_0000_00_00_0000);
    cyc(0, OP_NONE, 0); chk("merged_idle2", outs(), 16'b0000_0000_00_00_0000);
    @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("reset2_outputs", outs(), 16'b0000_0000_00_00_0000);
`ifdef MEM_SEQ_PERF_EN
    chk("reset2_cnt", 16'(bus.stall_cycles), 16'd0);
    chk("reset2_cnt_w2", 16'(bus2.stall_cycles), 16'd0);
`endif
    @(posedge clk);
    #1 reset = 1'b1;
    cyc(1, OP_RET, 0);  chk("perf_ret_b0", outs(), 16'b0000_1001_10_00_0001);
    cyc(0, OP_NONE, 0); chk("perf_ret_hi", outs(), 16'b0000_1001_10_00_0001);
    cyc(0, OP_NONE, 1); chk("perf_ret_pc", outs(), 16'b0000_0000_00_00_1000);
    cyc(0, OP_NONE, 0); chk("perf_idle", outs(), 16'b0000_0000_00_00_0000);
    cyc(0, OP_NONE, 0); chk("perf_int_fl", outs(), 16'b0000_0110_10_00_0001);
    cyc(0, OP_NONE, 0); chk("perf_int_hi", outs(), 16'b0000_0110_10_01_0001);
    cyc(0, OP_NONE, 0); chk("perf_int_lo", outs(), 16'b0000_0110_10_10_0101);
    cyc(0, OP_NONE, 0); chk("perf_done", outs(), 16'b0000_0000_00_00_0000);
`ifdef MEM_SEQ_PERF_EN
    chk("stall_cycles", 16'(bus.stall_cycles), 16'd5);
    chk("stall_cycles_sat", 16'(bus2.stall_cycles), 16'd3);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
